alu_seq_unit: RTL and testbench
===============================

# alu_seq_unit

Parametrised, registered execute-stage ALU with a persistent condition-code register (C/Z/N), an extended operation set, and an iterative multi-cycle shifter behind a valid/ready handshake. It is the successor to the combinational execute-stage ALU and sits between the ID/EX and EX/MEM pipeline registers. Flags live inside the block and can be restored directly, which the interrupt/RTI path uses.

## Interface
- N, 16, datapath width in bits (N ≥ 4, power of two)
- SW, $clog2(N), shift-amount width (derived; not to be overridden)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operation presented this cycle
- in_ready  out  1  block can accept an operation this cycle
- op  in  4  operation code (see Operation)
- in_src  in  N  source operand; bits [SW-1:0] give the shift amount
- in_dst  in  N  destination operand
- flags_load  in  1  load flags_in into the CCR this cycle
- flags_in  in  3  {C,Z,N} value to restore
- out  out  N  registered result
- out_valid  out  1  one-cycle pulse: out and flags hold a new result
- carryFlag, zeroFlag, negFlag  out  1 each  registered CCR bits

## Operation
- Accept: in_valid && in_ready at a rising edge. in_ready = (state == IDLE) && !rst, combinational.
- Opcodes: 0 NOP; 1 ADD {C,out}=dst+src; 2 SUB out=dst−src, C=1 on borrow (src > dst unsigned); 3 AND; 4 OR; 5 NOT ~dst; 6 MOV out=dst; 7 INC dst+1; 8 DEC dst−1, C=1 on borrow; 9 SHL dst by src[SW-1:0]; 10 SHR dst logical by src[SW-1:0]; 11 SETC; 12 CLRC; 13–15 reserved, treated as NOP.
- Arithmetic is modulo 2^N, with the carry taken from bit N of an N+1-bit sum/difference.
- Flag updates:
  - ADD/SUB/INC/DEC write C, Z, N.
  - AND/OR/NOT/MOV write Z and N; C is held.
  - SHL/SHR write Z and N. C = last bit shifted out; C is held when the amount is 0.
  - SETC/CLRC write only C, with no out_valid. NOP and reserved codes change nothing.
- Z = (out == 0); N = out[N-1], always evaluated on the final result.
- FSM:
  - IDLE: a non-shift op completes at the accept edge. A shift op with amount k > 0 loads the working register with dst and a counter with k, then moves to SHIFT.
  - SHIFT: shifts one bit per cycle and decrements the counter. When the counter reaches 0, it writes out and flags, pulses out_valid and returns to IDLE.
  - A shift with k = 0 completes in IDLE like a single-cycle op: out = dst.
- flags_load: the CCR takes flags_in at that edge. It has priority over any flag write from an op completing on the same edge; out and out_valid are unaffected.
- out holds its last value between results.

## Timing
- Reset (synchronous): out=0, out_valid=0, C=Z=N=0, state=IDLE, counter=0. in_ready is 0 while rst is high and 1 on the first cycle after.
- Single-cycle ops: accepted at edge t; out, flags and out_valid=1 are visible after edge t; out_valid drops after edge t+1 unless another result completes.
- Back-to-back single-cycle ops give one result per cycle; in_ready stays high.
- Shift with amount k ≥ 1: accepted at edge t; the result appears after edge t+k. in_ready is low for k cycles (after edges t … t+k−1). Throughput is 1/(k+1).
- in_valid while in_ready=0 is ignored (no capture); the producer must hold or re-present the operation.
- rst during SHIFT aborts the shift: no out_valid, state returns to IDLE, and all flags clear.
- flags_load during SHIFT updates the CCR immediately. The shift's completion later overwrites Z, N and C per the rules above.

## Configuration
- ALU_SHIFTER_EN defined: opcodes 9/10 are implemented as above, with the SHIFT state and counter.
- ALU_SHIFTER_EN undefined:
  - Opcodes 9/10 decode as NOP; no SHIFT state or counter is synthesised.
  - in_ready = !rst.
  - Every op is single-cycle.

## Test plan
- Reset: hold rst 2 cycles mid-stream → out=0x0000, out_valid=0, C/Z/N=0, in_ready=0 during rst and 1 after.
- ADD 0xFFFF+0x0001 → out=0x0000, C=1, Z=1, N=0, out_valid for one cycle. Follow with AND 0x8000&0xFFFF → out=0x8000, C still 1, Z=0, N=1.
- SUB dst=0x0003, src=0x0005 → out=0xFFFE, C=1, N=1. Then CLRC → C=0, no out_valid, Z/N unchanged.
- SHL dst=0xC001 by 3 (ALU_SHIFTER_EN) → in_ready low 3 cycles, out=0x0008, C=0, out_valid after edge t+3. SHR 0x0003 by 1 → out=0x0001, C=1. Shift by 0 → out=dst, C held, 1 cycle.
- flags_load with flags_in=3'b101 on the same edge that an ADD completes → CCR = C=1, Z=0, N=1, out holds the ADD result.
- rst asserted 2 cycles into an SHL by 15 → no out_valid, IDLE, flags 0. Without ALU_SHIFTER_EN, op 9 → no out_valid, nothing changes.

Source files
------------

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - registered execute-stage ALU with C/Z/N condition-code register; iterative shifter enabled by ALU_SHIFTER_EN
module alu_seq_unit #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [N-1:0] in_src,
    input  logic [N-1:0] in_dst,
    input  logic         flags_load,
    input  logic [2:0]   flags_in,
    output logic [N-1:0] out,
    output logic         out_valid,
    output logic         carryFlag,
    output logic         zeroFlag,
    output logic         negFlag
);

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_MOV  = 4'd6;
    localparam logic [3:0] OP_INC  = 4'd7;
    localparam logic [3:0] OP_DEC  = 4'd8;
    localparam logic [3:0] OP_SHL  = 4'd9;
    localparam logic [3:0] OP_SHR  = 4'd10;
    localparam logic [3:0] OP_SETC = 4'd11;
    localparam logic [3:0] OP_CLRC = 4'd12;

    localparam logic [N:0] ONE_EXT = {{N{1'b0}}, 1'b1};

    logic [N-1:0] out_q;
    logic         out_valid_q;
    logic         c_q, z_q, n_q;

    logic [N:0]   sum_d;
    logic [N-1:0] res_d;
    logic         c_d;
    logic         wr_c_d;
    logic         wr_zn_d;
    logic         done_d;
    logic         start_shift_d;

`ifdef ALU_SHIFTER_EN
    localparam int SW = $clog2(N);
    localparam logic [SW-1:0] CNT_ONE = {{(SW-1){1'b0}}, 1'b1};

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t       state_q;
    logic [N-1:0] work_q;
    logic [SW-1:0] cnt_q;
    logic         dir_q;
    logic [N-1:0] step_d;
    logic         bit_out_d;
    logic [SW-1:0] amt_d;

    assign amt_d    = in_src[SW-1:0];
    assign in_ready = (state_q == S_IDLE) && !rst;

    // One-bit shift of the working register; dir_q=1 is a logical right shift
    always_comb begin
        if (dir_q) begin
            step_d    = {1'b0, work_q[N-1:1]};
            bit_out_d = work_q[0];
        end else begin
            step_d    = {work_q[N-2:0], 1'b0};
            bit_out_d = work_q[N-1];
        end
    end
`else
    assign in_ready = !rst;
`endif

    // Decode the presented op into a result and which CCR fields it writes
    always_comb begin
        sum_d         = '0;
        res_d         = out_q;
        c_d           = c_q;
        wr_c_d        = 1'b0;
        wr_zn_d       = 1'b0;
        done_d        = 1'b0;
        start_shift_d = 1'b0;
        case (op)
            OP_ADD: begin
                sum_d = {1'b0, in_dst} + {1'b0, in_src};
                res_d = sum_d[N-1:0];
                c_d   = sum_d[N];
                {wr_c_d, wr_zn_d, done_d} = 3'b111;
            end
            OP_SUB: begin
                sum_d = {1'b0, in_dst} - {1'b0, in_src};
                res_d = sum_d[N-1:0];
                c_d   = sum_d[N];
                {wr_c_d, wr_zn_d, done_d} = 3'b111;
            end
            OP_INC: begin
                sum_d = {1'b0, in_dst} + ONE_EXT;
                res_d = sum_d[N-1:0];
                c_d   = sum_d[N];
                {wr_c_d, wr_zn_d, done_d} = 3'b111;
            end
            OP_DEC: begin
                sum_d = {1'b0, in_dst} - ONE_EXT;
                res_d = sum_d[N-1:0];
                c_d   = sum_d[N];
                {wr_c_d, wr_zn_d, done_d} = 3'b111;
            end
            OP_AND: begin
                res_d = in_dst & in_src;
                {wr_zn_d, done_d} = 2'b11;
            end
            OP_OR: begin
                res_d = in_dst | in_src;
                {wr_zn_d, done_d} = 2'b11;
            end
            OP_NOT: begin
                res_d = ~in_dst;
                {wr_zn_d, done_d} = 2'b11;
            end
            OP_MOV: begin
                res_d = in_dst;
                {wr_zn_d, done_d} = 2'b11;
            end
`ifdef ALU_SHIFTER_EN
            OP_SHL, OP_SHR: begin
                // A zero-length shift is just a move that keeps C
                if (amt_d == '0) begin
                    res_d = in_dst;
                    {wr_zn_d, done_d} = 2'b11;
                end else begin
                    start_shift_d = 1'b1;
                end
            end
`endif
            OP_SETC: begin
                c_d    = 1'b1;
                wr_c_d = 1'b1;
            end
            OP_CLRC: begin
                c_d    = 1'b0;
                wr_c_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Result, CCR and shift FSM; flags_load is applied last so it wins over op flag writes
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            n_q         <= 1'b0;
`ifdef ALU_SHIFTER_EN
            state_q     <= S_IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
`endif
        end else begin
            out_valid_q <= 1'b0;
`ifdef ALU_SHIFTER_EN
            if (state_q == S_SHIFT) begin
                work_q <= step_d;
                cnt_q  <= cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    out_q       <= step_d;
                    out_valid_q <= 1'b1;
                    c_q         <= bit_out_d;
                    z_q         <= (step_d == '0);
                    n_q         <= step_d[N-1];
                    state_q     <= S_IDLE;
                end
            end else if (in_valid && start_shift_d) begin
                work_q  <= in_dst;
                cnt_q   <= amt_d;
                dir_q   <= (op == OP_SHR);
                state_q <= S_SHIFT;
            end else
`endif
            if (in_valid) begin
                if (done_d) begin
                    out_q       <= res_d;
                    out_valid_q <= 1'b1;
                end
                if (wr_c_d) begin
                    c_q <= c_d;
                end
                if (wr_zn_d) begin
                    z_q <= (res_d == '0);
                    n_q <= res_d[N-1];
                end
            end
            if (flags_load) begin
                {c_q, z_q, n_q} <= flags_in;
            end
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign carryFlag = c_q;
    assign zeroFlag  = z_q;
    assign negFlag   = n_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - directed self-checking bench for alu_seq_unit
module tb_alu_seq_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [15:0] in_src;
    logic [15:0] in_dst;
    logic        flags_load;
    logic [2:0]  flags_in;
    logic [15:0] out;
    logic        out_valid;
    logic        carryFlag;
    logic        zeroFlag;
    logic        negFlag;

    int checks   = 0;
    int failures = 0;

    alu_seq_unit #(.N(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .in_src     (in_src),
        .in_dst     (in_dst),
        .flags_load (flags_load),
        .flags_in   (flags_in),
        .out        (out),
        .out_valid  (out_valid),
        .carryFlag  (carryFlag),
        .zeroFlag   (zeroFlag),
        .negFlag    (negFlag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic [2:0] exp_czn);
        chk(tag, {29'd0, carryFlag, zeroFlag, negFlag}, {29'd0, exp_czn});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [15:0] d, input logic [15:0] s);
        @(negedge clk);
        op       = o;
        in_dst   = d;
        in_src   = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        flags_load = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst        = 1'b1;
        in_valid   = 1'b0;
        flags_load = 1'b0;
        tick();
        chk({tag, "_ready_in_rst1"}, in_ready, 1'b0);
        tick();
        chk({tag, "_ready_in_rst2"}, in_ready, 1'b0);
        chk({tag, "_out"}, out, 16'h0000);
        chk({tag, "_valid"}, out_valid, 1'b0);
        chk_flags({tag, "_flags"}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk({tag, "_ready_after"}, in_ready, 1'b1);
    endtask

    initial begin
        int pulses;
        rst        = 1'b1;
        in_valid   = 1'b0;
        op         = 4'd0;
        in_src     = 16'h0;
        in_dst     = 16'h0;
        flags_load = 1'b0;
        flags_in   = 3'b000;

        do_reset("rst0");

        // ADD with wrap-around, then AND back-to-back
        issue(4'd1, 16'hFFFF, 16'h0001);
        chk("add_out", out, 16'h0000);
        chk("add_valid", out_valid, 1'b1);
        chk_flags("add_flags", 3'b110);
        chk("add_ready", in_ready, 1'b1);
        issue(4'd3, 16'h8000, 16'hFFFF);
        chk("and_out", out, 16'h8000);
        chk("and_valid", out_valid, 1'b1);
        chk_flags("and_flags", 3'b101);
        tick();
        chk("idle_valid_drop", out_valid, 1'b0);
        chk("idle_out_hold", out, 16'h8000);

        // SUB with borrow, then CLRC
        issue(4'd2, 16'h0003, 16'h0005);
        chk("sub_out", out, 16'hFFFE);
        chk_flags("sub_flags", 3'b101);
        issue(4'd12, 16'h1111, 16'h2222);
        chk("clrc_valid", out_valid, 1'b0);
        chk("clrc_out_hold", out, 16'hFFFE);
        chk_flags("clrc_flags", 3'b001);
        issue(4'd11, 16'h0000, 16'h0000);
        chk("setc_valid", out_valid, 1'b0);
        chk_flags("setc_flags", 3'b101);

        // INC / DEC / NOT / MOV
        issue(4'd7, 16'hFFFF, 16'h0000);
        chk("inc_out", out, 16'h0000);
        chk_flags("inc_flags", 3'b110);
        issue(4'd8, 16'h0000, 16'h0000);
        chk("dec_out", out, 16'hFFFF);
        chk_flags("dec_flags", 3'b101);
        issue(4'd8, 16'h0005, 16'h0000);
        chk("dec2_out", out, 16'h0004);
        chk_flags("dec2_flags", 3'b000);
        issue(4'd5, 16'h00FF, 16'h0000);
        chk("not_out", out, 16'hFF00);
        chk_flags("not_flags", 3'b001);
        issue(4'd6, 16'h0000, 16'h1234);
        chk("mov_out", out, 16'h0000);
        chk_flags("mov_flags", 3'b010);

        // flags_load overrides the ADD flag write on the same edge
        flags_load = 1'b1;
        flags_in   = 3'b101;
        issue(4'd1, 16'h0001, 16'h0002);
        chk("fl_out", out, 16'h0003);
        chk("fl_valid", out_valid, 1'b1);
        chk_flags("fl_flags", 3'b101);

        // Reserved opcode changes nothing
        issue(4'd13, 16'hAAAA, 16'h5555);
        chk("rsv_valid", out_valid, 1'b0);
        chk("rsv_out", out, 16'h0003);
        chk_flags("rsv_flags", 3'b101);

        do_reset("rst_mid");

        issue(4'd11, 16'h0000, 16'h0000);
        chk_flags("setc2_flags", 3'b100);

`ifdef ALU_SHIFTER_EN
        // SHL 0xC001 by 3, with an ignored op offered while busy
        issue(4'd9, 16'hC001, 16'h0003);
        chk("shl_ready_t0", in_ready, 1'b0);
        chk("shl_valid_t0", out_valid, 1'b0);
        @(negedge clk);
        op       = 4'd1;
        in_dst   = 16'h0001;
        in_src   = 16'h0001;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("shl_ready_t1", in_ready, 1'b0);
        chk("shl_valid_t1", out_valid, 1'b0);
        tick();
        chk("shl_ready_t2", in_ready, 1'b0);
        tick();
        chk("shl_out", out, 16'h0008);
        chk("shl_valid", out_valid, 1'b1);
        chk_flags("shl_flags", 3'b000);
        chk("shl_ready_done", in_ready, 1'b1);
        tick();
        chk("shl_busy_op_ignored", out_valid, 1'b0);
        chk("shl_out_hold", out, 16'h0008);

        // SHR 0x0003 by 1
        issue(4'd10, 16'h0003, 16'h0001);
        chk("shr_ready_t0", in_ready, 1'b0);
        tick();
        chk("shr_out", out, 16'h0001);
        chk("shr_valid", out_valid, 1'b1);
        chk_flags("shr_flags", 3'b100);

        // Shift by zero: single cycle, C held
        issue(4'd9, 16'h8000, 16'h0000);
        chk("sh0_out", out, 16'h8000);
        chk("sh0_valid", out_valid, 1'b1);
        chk("sh0_ready", in_ready, 1'b1);
        chk_flags("sh0_flags", 3'b101);

        // Reset two cycles into SHL by 15 aborts the shift
        issue(4'd9, 16'h1234, 16'h000F);
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk("abort_valid_in_rst", out_valid, 1'b0);
        chk("abort_ready_in_rst", in_ready, 1'b0);
        tick();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_flags("abort_flags", 3'b000);
        chk("abort_out", out, 16'h0000);
        chk("abort_ready", in_ready, 1'b1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) pulses++;
        end
        chk("abort_no_result", pulses, 0);
`else
        // Without the shifter, op 9 is a NOP
        issue(4'd9, 16'h1234, 16'h0001);
        chk("op9_valid", out_valid, 1'b0);
        chk("op9_out", out, 16'h0000);
        chk("op9_ready", in_ready, 1'b1);
        chk_flags("op9_flags", 3'b100);
        issue(4'd1, 16'h0010, 16'h0020);
        chk("op9_next_out", out, 16'h0030);
        chk_flags("op9_next_flags", 3'b000);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
